// File: rtl/down_timer_if.sv
// Control and status bundle of the down_timer: the controller (master) drives
// requests and the timer (slave) returns its registered count, busy and tc.
interface down_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             tick;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;

    modport master (
        output load, load_val, start, stop, tick, auto_reload,
        input  count, busy, tc
    );

    modport slave (
        input  load, load_val, start, stop, tick, auto_reload,
        output count, busy, tc
    );
endinterface

// File: rtl/down_timer.sv
// Synchronous loadable down-counter with one-shot/auto-reload modes, pause/resume,
// a prescale tick input and a registered single-cycle terminal-count pulse.
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    down_timer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] count_r, count_n;
    logic [WIDTH-1:0] reload_r, reload_n;
    logic             busy_r, busy_n;
    logic             tc_r, tc_n;

    logic             do_stop, do_start, do_tick, terminal;

    // Request decode in priority order load > stop > start > tick; stop outside
    // RUN still masks start, and start inside RUN leaves tick free to act.
    assign do_stop  = !bus.load && bus.stop && (state == RUN);
    assign do_start = !bus.load && !bus.stop && bus.start && (state != RUN) && (count_r != '0);
    assign do_tick  = !bus.load && !bus.stop && bus.tick && (state == RUN);
    assign terminal = do_tick && (count_r == WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count_r  <= '0;
            reload_r <= '0;
            busy_r   <= 1'b0;
            tc_r     <= 1'b0;
        end else begin
            state    <= state_n;
            count_r  <= count_n;
            reload_r <= reload_n;
            busy_r   <= busy_n;
            tc_r     <= tc_n;
        end
    end

    always_comb begin
        state_n = state;
        if (bus.load)
            state_n = IDLE;
        else if (do_stop)
            state_n = HOLD;
        else if (do_start)
            state_n = RUN;
        else if (terminal && !bus.auto_reload)
            state_n = IDLE;
    end

    // The terminal decrement reloads instead of showing 0 in periodic mode, so
    // with a reload value of 1 the count sits at 1 and tc stays high.
    always_comb begin
        count_n  = count_r;
        reload_n = reload_r;
        tc_n     = 1'b0;
        if (bus.load) begin
            count_n  = bus.load_val;
            reload_n = bus.load_val;
        end else if (terminal) begin
            tc_n    = 1'b1;
            count_n = bus.auto_reload ? reload_r : '0;
        end else if (do_tick && (count_r != '0)) begin
            count_n = count_r - WIDTH'(1);
        end
        busy_n = (state_n == RUN);
    end

    assign bus.count = count_r;
    assign bus.busy  = busy_r;
    assign bus.tc    = tc_r;
endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios followed by random
// traffic, all compared against a behavioural model of the timer's rules.
module tb_down_timer;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    int   m_count;
    int   m_reload;
    bit   m_running;
    bit   m_tc;

    down_timer_if #(.WIDTH(WIDTH)) bus ();

    down_timer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "_count"}, 32'(bus.count), 32'(m_count));
        checkVal({tag, "_busy"},  32'(bus.busy),  32'(m_running));
        checkVal({tag, "_tc"},    32'(bus.tc),    32'(m_tc));
    endtask

    task automatic modelReset();
        m_count   = 0;
        m_reload  = 0;
        m_running = 1'b0;
        m_tc      = 1'b0;
    endtask

    // Externally, a stopped timer looks the same whether it was never started
    // or was paused, so the model only tracks whether it is running.
    task automatic modelStep(input bit ld, input int lv, input bit st, input bit sp, input bit tk, input bit ar);
        if (ld) begin
            m_count   = lv;
            m_reload  = lv;
            m_running = 1'b0;
            m_tc      = 1'b0;
        end else if (sp) begin
            m_running = 1'b0;
            m_tc      = 1'b0;
        end else if (st && !m_running) begin
            if (m_count != 0) m_running = 1'b1;
            m_tc = 1'b0;
        end else if (m_running && tk) begin
            if (m_count == 1) begin
                m_tc      = 1'b1;
                m_count   = ar ? m_reload : 0;
                m_running = ar;
            end else begin
                m_count = m_count - 1;
                m_tc    = 1'b0;
            end
        end else begin
            m_tc = 1'b0;
        end
    endtask

    task automatic applyStimulus(input string tag, input bit ld, input int lv, input bit st,
                                 input bit sp, input bit tk, input bit ar);
        @(negedge clk);
        bus.load        = ld;
        bus.load_val    = WIDTH'(lv);
        bus.start       = st;
        bus.stop        = sp;
        bus.tick        = tk;
        bus.auto_reload = ar;
        modelStep(ld, lv, st, sp, tk, ar);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int tc_seen;
        errors          = 0;
        checks          = 0;
        rst_n           = 1'b0;
        bus.load        = 1'b0;
        bus.load_val    = '0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.tick        = 1'b0;
        bus.auto_reload = 1'b0;
        modelReset();

        #12;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset mid-run");
        applyStimulus("rst_load", 1, 8, 0, 0, 0, 0);
        applyStimulus("rst_start", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus("rst_run", 0, 0, 0, 0, 1, 0);
        checkVal("rst_pre_count", 32'(bus.count), 32'd5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("rst_start_zero", 0, 0, 1, 0, 1, 0);

        $display("[TB] one-shot");
        applyStimulus("os_load", 1, 4, 0, 0, 0, 0);
        applyStimulus("os_start", 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 6; i++) applyStimulus("os_run", 0, 0, 0, 0, 1, 0);

        $display("[TB] auto-reload");
        applyStimulus("ar_load", 1, 3, 0, 0, 0, 1);
        applyStimulus("ar_start", 0, 0, 1, 0, 1, 1);
        for (int i = 0; i < 10; i++) applyStimulus("ar_run", 0, 0, 0, 0, 1, 1);

        $display("[TB] pause and prescale");
        applyStimulus("pp_load", 1, 6, 0, 0, 0, 0);
        applyStimulus("pp_start", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus("pp_run", 0, 0, 0, 0, (i % 2) == 1, 0);
        applyStimulus("pp_stop", 0, 0, 0, 1, 0, 0);
        checkVal("pp_frozen", 32'(bus.count), 32'd4);
        for (int i = 0; i < 5; i++) applyStimulus("pp_hold", 0, 0, 0, 0, 1, 0);
        applyStimulus("pp_resume", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus("pp_run2", 0, 0, 0, 0, (i % 2) == 1, 0);

        $display("[TB] priority");
        applyStimulus("pr_load", 1, 2, 0, 0, 0, 0);
        applyStimulus("pr_start", 0, 0, 1, 0, 0, 0);
        applyStimulus("pr_dec", 0, 0, 0, 0, 1, 0);
        applyStimulus("pr_all", 1, 9, 1, 1, 1, 0);
        checkVal("pr_count9", 32'(bus.count), 32'd9);
        applyStimulus("pr_start2", 0, 0, 1, 0, 0, 0);
        applyStimulus("pr_stop", 0, 0, 0, 1, 1, 0);
        applyStimulus("pr_both", 0, 0, 1, 1, 1, 0);
        applyStimulus("pr_hold", 0, 0, 0, 0, 1, 0);

        $display("[TB] boundary period 15");
        applyStimulus("b15_load", 1, 15, 0, 0, 0, 1);
        applyStimulus("b15_start", 0, 0, 1, 0, 1, 1);
        tc_seen = 0;
        for (int i = 0; i < 45; i++) begin
            applyStimulus("b15_run", 0, 0, 0, 0, 1, 1);
            if (bus.tc) tc_seen++;
        end
        checkVal("b15_tc_pulses", 32'(tc_seen), 32'd3);

        $display("[TB] boundary period 1");
        applyStimulus("b1_load", 1, 1, 0, 0, 0, 1);
        applyStimulus("b1_start", 0, 0, 1, 0, 1, 1);
        tc_seen = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus("b1_run", 0, 0, 0, 0, 1, 1);
            if (bus.tc) tc_seen++;
        end
        checkVal("b1_tc_pulses", 32'(tc_seen), 32'd5);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            bit ld, st, sp, tk, ar;
            int lv;
            ld = ($urandom_range(0, 15) == 0);
            lv = $urandom_range(0, 15);
            st = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 9) == 0);
            tk = ($urandom_range(0, 3) != 0);
            ar = ((i / 50) % 2) == 1;
            applyStimulus("rand", ld, lv, st, sp, tk, ar);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
